// File: rtl/p4_router_ps_ingress_arb.sv
// rtl/p4_router_ps_ingress_arb.sv - round-robin packet arbiter merging PS ingress links into one router stream
//
// Purpose:
//   Merges NUM_PORTS packet streams into a single stream. Arbitration is
//   round-robin per packet, and a granted port keeps the grant until its
//   tlast beat is transferred. Packets longer than MTU_BEATS are cut at beat
//   MTU_BEATS. That beat is marked with tlast=1 and tuser oversize_err=1, and
//   the rest of the input packet is drained without being forwarded.
//
// Ports:
//   i_core_clk                 sole clock, rising edge
//   i_core_sreset              synchronous active-high reset
//   i_ingress_from_ps_tdata    per-port tdata, port p at [p*8*DATA_BYTES +: 8*DATA_BYTES]
//   i_ingress_from_ps_tvalid   per-port tvalid
//   i_ingress_from_ps_tlast    per-port tlast
//   o_ingress_from_ps_tready   per-port tready
//   o_router_ing_tdata         merged tdata
//   o_router_ing_tvalid        merged tvalid
//   i_router_ing_tready        merged tready from the router
//   o_router_ing_tlast         merged tlast (forced high on a truncating beat)
//   o_router_ing_tuser         {oversize_err, port_id}
//   o_oversize_pulse           one-cycle strobe per truncated packet
//   o_oversize_port            source port of the last truncated packet

module p4_router_ps_ingress_arb #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_BYTES = 1,
  parameter int MTU_BYTES  = 2000,
  localparam int MTU_BEATS     = (MTU_BYTES + DATA_BYTES - 1) / DATA_BYTES,
  localparam int PORT_ID_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int TDATA_W       = 8 * DATA_BYTES,
  localparam int CNT_W         = $clog2(MTU_BEATS + 1)
) (
  input  logic                           i_core_clk,
  input  logic                           i_core_sreset,
  input  logic [NUM_PORTS*TDATA_W-1:0]   i_ingress_from_ps_tdata,
  input  logic [NUM_PORTS-1:0]           i_ingress_from_ps_tvalid,
  input  logic [NUM_PORTS-1:0]           i_ingress_from_ps_tlast,
  output logic [NUM_PORTS-1:0]           o_ingress_from_ps_tready,
  output logic [TDATA_W-1:0]             o_router_ing_tdata,
  output logic                           o_router_ing_tvalid,
  input  logic                           i_router_ing_tready,
  output logic                           o_router_ing_tlast,
  output logic [PORT_ID_WIDTH:0]         o_router_ing_tuser,
  output logic                           o_oversize_pulse,
  output logic [PORT_ID_WIDTH-1:0]       o_oversize_port
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PASS    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;

  logic [PORT_ID_WIDTH-1:0] r_grant;
  logic [PORT_ID_WIDTH-1:0] r_last_grant;
  logic [CNT_W-1:0]         r_beat_cnt;
  logic                     r_oversize_pulse;
  logic [PORT_ID_WIDTH-1:0] r_oversize_port;

  // Round-robin search results
  logic                     w_hi_found;
  logic [PORT_ID_WIDTH-1:0] w_hi_pick;
  logic                     w_lo_found;
  logic [PORT_ID_WIDTH-1:0] w_lo_pick;
  logic                     w_found;
  logic [PORT_ID_WIDTH-1:0] w_pick;

  // Granted-port view
  logic [TDATA_W-1:0]       w_sel_tdata;
  logic                     w_sel_tvalid;
  logic                     w_sel_tlast;

  // Beat accounting
  logic [CNT_W:0]           w_beat_num;
  logic                     w_at_mtu;
  logic                     w_trunc;

  // FSM-decoded controls
  logic                     w_port_ready;
  logic                     w_take_grant;
  logic                     w_beat_xfer;
  logic                     w_oversize_hit;

  // Round-robin pick. Ports above last_grant form the high group, and the
  // rest form the wrapped low group. Scanning downward leaves the
  // lowest-numbered valid port of each group in the pick variables. The high
  // group wins whenever it has a requester.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_pick  = '0;
    w_lo_found = 1'b0;
    w_lo_pick  = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (i_ingress_from_ps_tvalid[p]) begin
        if (p > int'(r_last_grant)) begin
          w_hi_found = 1'b1;
          w_hi_pick  = PORT_ID_WIDTH'(p);
        end else begin
          w_lo_found = 1'b1;
          w_lo_pick  = PORT_ID_WIDTH'(p);
        end
      end
    end
    w_found = w_hi_found | w_lo_found;
    w_pick  = w_hi_found ? w_hi_pick : w_lo_pick;
  end

  // Granted-port mux
  always_comb begin
    w_sel_tdata  = '0;
    w_sel_tvalid = 1'b0;
    w_sel_tlast  = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_grant == PORT_ID_WIDTH'(p)) begin
        w_sel_tdata  = i_ingress_from_ps_tdata[p*TDATA_W +: TDATA_W];
        w_sel_tvalid = i_ingress_from_ps_tvalid[p];
        w_sel_tlast  = i_ingress_from_ps_tlast[p];
      end
    end
  end

  // r_beat_cnt counts beats already transferred, so the beat now on the
  // bus is number r_beat_cnt+1 (1-based).
  assign w_beat_num = {1'b0, r_beat_cnt} + (CNT_W+1)'(1);
  assign w_at_mtu   = (w_beat_num == (CNT_W+1)'(MTU_BEATS));
  assign w_trunc    = (r_state == ST_PASS) && w_at_mtu && !w_sel_tlast;

  // State register
  always_ff @(posedge i_core_clk) begin
    if (i_core_sreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and handshake decode
  always_comb begin
    w_next_state        = r_state;
    w_port_ready        = 1'b0;
    o_router_ing_tvalid = 1'b0;
    w_take_grant        = 1'b0;
    w_beat_xfer         = 1'b0;
    w_oversize_hit      = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_take_grant = 1'b1;
          w_next_state = ST_PASS;
        end
      end

      ST_PASS: begin
        o_router_ing_tvalid = w_sel_tvalid;
        w_port_ready        = i_router_ing_tready;
        if (w_sel_tvalid && i_router_ing_tready) begin
          w_beat_xfer = 1'b1;
          if (w_sel_tlast) begin
            w_next_state = ST_IDLE;
          end else if (w_at_mtu) begin
            w_next_state   = ST_DISCARD;
            w_oversize_hit = 1'b1;
          end
        end
      end

      ST_DISCARD: begin
        w_port_ready = 1'b1;
        if (w_sel_tvalid && w_sel_tlast) begin
          w_next_state = ST_IDLE;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    // While reset is held, nothing may transfer on either side. Otherwise a
    // beat could be consumed from a link in the very cycle that aborts the
    // packet.
    if (i_core_sreset) begin
      o_router_ing_tvalid = 1'b0;
      w_port_ready        = 1'b0;
      w_beat_xfer         = 1'b0;
      w_oversize_hit      = 1'b0;
      w_take_grant        = 1'b0;
    end
  end

  // Grant, beat counter and oversize bookkeeping
  always_ff @(posedge i_core_clk) begin
    if (i_core_sreset) begin
      r_grant          <= '0;
      r_last_grant     <= PORT_ID_WIDTH'(NUM_PORTS - 1);
      r_beat_cnt       <= '0;
      r_oversize_pulse <= 1'b0;
      r_oversize_port  <= '0;
    end else begin
      r_oversize_pulse <= w_oversize_hit;
      if (w_take_grant) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
        r_beat_cnt   <= '0;
      end else if (w_beat_xfer) begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
      if (w_oversize_hit) begin
        r_oversize_port <= r_grant;
      end
    end
  end

  always_comb begin
    o_ingress_from_ps_tready = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      o_ingress_from_ps_tready[p] = w_port_ready && (r_grant == PORT_ID_WIDTH'(p));
    end
  end

  assign o_router_ing_tdata = w_sel_tdata;
  assign o_router_ing_tlast = w_sel_tlast | w_trunc;
  assign o_router_ing_tuser = {w_trunc, r_grant};
  assign o_oversize_pulse   = r_oversize_pulse;
  assign o_oversize_port    = r_oversize_port;

endmodule

// File: doc/p4_router_ps_ingress_arb.md
P4_ROUTER_PS_INGRESS_ARB -- requirements
Module: p4_router_ps_ingress_arb

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of PS-to-PL ingress links arbitrated (1..16).
REQ-002 SHALL have parameter DATA_BYTES, default 1: tdata width in bytes on all ports.
REQ-003 SHALL have parameter MTU_BYTES, default 2000: maximum forwarded packet length; MTU_BEATS = ceil(MTU_BYTES/DATA_BYTES).
REQ-004 SHALL have derived parameter PORT_ID_WIDTH = max(1, clog2(NUM_PORTS)).
REQ-005 core_clk_ifc  input  Clock_int  sole clock; every register updates on its rising edge.
REQ-006 core_sreset_ifc  input  Reset_int  reset is synchronous and active-high.
REQ-007 ingress_from_ps  input (AXIS_int.Slave array [NUM_PORTS-1:0])  8*DATA_BYTES tdata, tvalid, tready, tlast  per-link packet streams.
REQ-008 router_ing  output (AXIS_int.Master)  8*DATA_BYTES tdata, tlast, tuser PORT_ID_WIDTH+1  merged stream; tuser = {oversize_err, port_id}.
REQ-009 oversize_pulse  output  1  one-cycle strobe per truncated packet.
REQ-010 oversize_port  output  PORT_ID_WIDTH  source port of the last truncated packet.

Function
REQ-011 SHALL implement FSM states IDLE, PASS, DISCARD.
REQ-012 In IDLE, SHALL pick the first port with tvalid=1, searching (last_grant+1) mod NUM_PORTS upward with wrap; register grant and last_grant, go to PASS next cycle.
REQ-013 In IDLE, all ingress tready and router_ing.tvalid SHALL be 0; the arbitration bubble is exactly one cycle.
REQ-014 In PASS, router_ing tvalid/tdata/tlast SHALL combinationally follow the granted port, and granted tready = router_ing.tready; non-granted tready = 0.
REQ-015 Grant SHALL hold until the beat carrying tlast is transferred; no mid-packet port switch.
REQ-016 tuser port_id SHALL equal the grant on every beat; oversize_err SHALL be 0 except per REQ-018.
REQ-017 A beat counter SHALL reset to 0 entering PASS and increment per transferred beat; width clog2(MTU_BEATS+1).
REQ-018 On beat number MTU_BEATS (1-based) with input tlast=0, router_ing SHALL present tlast=1 and oversize_err=1.
REQ-019 When that beat transfers, SHALL go to DISCARD, assert oversize_pulse for one cycle, and load oversize_port with grant.
REQ-020 A packet with tlast on exactly beat MTU_BEATS SHALL pass unmodified (oversize_err=0), returning to IDLE.
REQ-021 In DISCARD, granted tready SHALL be 1, router_ing.tvalid 0; on transfer of input tlast go to IDLE.
REQ-022 PASS on transfer of tlast (REQ-015) SHALL return to IDLE; back-to-back requests incur the one-cycle bubble.
REQ-023 Backpressure (router_ing.tready=0) SHALL stall without dropping or duplicating beats; tdata/tlast/tuser stable while tvalid=1 and tready=0.
REQ-024 NUM_PORTS=1 SHALL elaborate and always grant port 0.

Reset
REQ-025 On reset: state IDLE, last_grant = NUM_PORTS-1 (port 0 wins first), beat counter 0, oversize_pulse 0, oversize_port 0, all tready 0, router_ing.tvalid 0.
REQ-026 Reset mid-packet SHALL abort the packet without emitting tlast; the next cycle after reset deassert behaves as IDLE.
REQ-027 Reset SHALL take priority over every transition in the same cycle.

Verification (NUM_PORTS=4, DATA_BYTES=1, MTU_BYTES=8 unless stated)
REQ-028 Ports 0..3 each hold a 3-beat packet from reset -> output order 0,1,2,3, tuser port_id 0..3, one idle cycle between packets, 12 data beats total.
REQ-029 Port 2 sends 12-beat packet -> 8 beats out, beat 8 tlast=1 tuser=3'b110, oversize_pulse once, oversize_port=2, input beats 9-12 consumed with no output.
REQ-030 Port 1 sends exactly 8 beats -> 8 beats out, tlast on beat 8, oversize_err=0, no pulse.
REQ-031 Port 0 mid-packet while port 3 tvalid=1, random router_ing.tready 50% -> port 0 packet completes contiguous and intact, then port 3 granted; ports 1-3 tready stay 0 meanwhile.
REQ-032 Reset asserted on beat 4 of a 6-beat port-1 packet -> all tready 0 and tvalid 0 next cycle, no tlast output; after release port 0 wins when ports 0 and 1 both request.
